// File: rtl/scr1_pipe_mprf_mp.sv
// ---------------------------------------------------------------------------
// scr1_pipe_mprf_mp
// Multi-port register file with a pending-write scoreboard for the
// superscalar SCR1 pipeline. Dispatch reads operands and reserves destination
// registers; writeback writes results and clears the reservation.
//
// Parameters
//   XLEN  : data width
//   NREGS : architectural registers including x0 (power of two, 2..64)
//   NRD   : number of combinational read ports
//   NWR   : number of write / reserve ports
//   AW    : address width, derived from NREGS
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   rs_addr   : NRD read addresses, port i at [i*AW +: AW]
//   rs_data   : NRD read data words
//   rs_busy   : pending flag of each read address
//   w_req     : write request per write port
//   w_addr    : write addresses
//   w_data    : write data
//   rsv_req   : reserve (mark pending) request per port
//   rsv_addr  : reserve addresses
//   flush     : clear every pending bit
//   pend_cnt  : registered number of pending registers
//
// Build option
//   SCR1_MPRF_BYPASS_EN : when defined, same-cycle writes are forwarded to
//                         the read ports; otherwise a write becomes visible
//                         one cycle later.
// ---------------------------------------------------------------------------
module scr1_pipe_mprf_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 4,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      w_req,
  input  logic [NWR*AW-1:0]   w_addr,
  input  logic [NWR*XLEN-1:0] w_data,
  input  logic [NWR-1:0]      rsv_req,
  input  logic [NWR*AW-1:0]   rsv_addr,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  if (NRD < 1) begin : g_bad_nrd
    $error("scr1_pipe_mprf_mp: NRD must be at least 1");
  end
  if (NWR < 1) begin : g_bad_nwr
    $error("scr1_pipe_mprf_mp: NWR must be at least 1");
  end
  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
    $error("scr1_pipe_mprf_mp: NREGS must be a power of two >= 2");
  end

  function automatic logic [AW:0] popcnt(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int k = 0; k < NREGS; k++) begin
      c = c + {{AW{1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Entry 0 exists only to keep indexing uniform; it is never written and
  // reads of x0 are forced to zero.
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic [NREGS-1:0] w_pend_nxt;

  // Scoreboard next state: write clears, reserve overrides write, flush
  // overrides everything.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int j = 0; j < NWR; j++) begin
      if (w_req[j]) w_pend_nxt[w_addr[j*AW +: AW]] = 1'b0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (rsv_req[j]) w_pend_nxt[rsv_addr[j*AW +: AW]] = 1'b1;
    end
    if (flush) w_pend_nxt = '0;
    w_pend_nxt[0] = 1'b0;
  end

  // Ascending port order makes the highest-index writer win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_req[j] && (w_addr[j*AW +: AW] != '0)) begin
          r_regs[w_addr[j*AW +: AW]] <= w_data[j*XLEN +: XLEN];
        end
      end
      r_pend <= w_pend_nxt;
      // Counted from the next-state vector so it is never a cycle behind.
      r_cnt  <= popcnt(w_pend_nxt);
    end
  end

  assign pend_cnt = r_cnt;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;
    logic            w_rb;
`ifdef SCR1_MPRF_BYPASS_EN
    logic            w_hitw;
    logic            w_hitr;
`endif

    assign w_ra = rs_addr[i*AW +: AW];

    always_comb begin
      w_rd = (w_ra == '0) ? '0 : r_regs[w_ra];
      w_rb = r_pend[w_ra];
`ifdef SCR1_MPRF_BYPASS_EN
      w_hitw = 1'b0;
      w_hitr = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (w_req[j] && (w_addr[j*AW +: AW] == w_ra) && (w_ra != '0)) begin
          w_rd   = w_data[j*XLEN +: XLEN];
          w_hitw = 1'b1;
        end
        if (rsv_req[j] && (rsv_addr[j*AW +: AW] == w_ra)) w_hitr = 1'b1;
      end
      // Forward the clear of a completing write, but never forward a reserve:
      // with a same-cycle reserve the current pending state is shown.
      if (w_hitw && !w_hitr) w_rb = 1'b0;
`endif
    end

    assign rs_data[i*XLEN +: XLEN] = w_rd;
    assign rs_busy[i]              = w_rb;
  end

endmodule

// File: doc/scr1_pipe_mprf_mp.md
Name: scr1_pipe_mprf_mp

Overview:
Parametrised multi-port register file for the superscalar SCR1 pipeline.
- Provides NRD combinational read ports and NWR synchronous write ports.
- Each register carries a pending-write scoreboard bit. Issue sets the bit (reserve); writeback clears it.
- Sits between the dispatch stage (reads, reserves) and the writeback stage (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers including x0 (16 for RVE); power of two, 2..64
NRD, 4, number of read ports
NWR, 2, number of write/reserve ports
AW, $clog2(NREGS), address width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rs_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
rs_data  out  NRD*XLEN  read data per port
rs_busy  out  NRD  pending-write flag of each read address
w_req  in  NWR  write request per port
w_addr  in  NWR*AW  write addresses
w_data  in  NWR*XLEN  write data
rsv_req  in  NWR  reserve (mark pending) request per port
rsv_addr  in  NWR*AW  reserve addresses
flush  in  1  clear all pending bits (pipeline kill)
pend_cnt  out  AW+1  number of registers currently pending

Behaviour:
Reset and x0
- rst high (asynchronous): all registers 1..NREGS-1 = 0, all pending bits = 0. Outputs follow from state: rs_data = 0, rs_busy = 0, pend_cnt = 0.
- Register x0 has no storage. It always reads 0 and is never busy. Writes and reserves to x0 are ignored.

Read
- Combinational, zero latency: rs_data[i] = reg[rs_addr[i]]; rs_busy[i] = pend[rs_addr[i]].
- Default (bypass macro off): a write in the current cycle is not visible until the next cycle.

Write
- On the clk rising edge with w_req[j] set and w_addr[j] != 0, reg[w_addr[j]] <= w_data[j].
- If several ports write the same address in one cycle, the highest port index wins.

Scoreboard, per register r != 0, at each clk edge:
- flush = 1: pend[r] <= 0, overriding everything, including reserves in the same cycle.
- Else, any rsv_req[j] with rsv_addr[j] == r: pend[r] <= 1. A reserve wins over a same-cycle write, because a newer producer supersedes the older one.
- Else, any w_req[j] with w_addr[j] == r: pend[r] <= 0.
- Else: pend[r] holds.
- A write to a non-pending register is legal and leaves pend at 0.
- Multiple reserves to the same register in one cycle are legal; the result is pend = 1.

Pending counter
- pend_cnt is a registered population count of pend[]. It updates in the same edge as pend and is never stale.
- Range 0..NREGS-1; it cannot overflow with AW+1 bits.

Reset mid-operation
- Assertion of rst discards any in-flight writes and reserves immediately; there is no deferred write.

Illegal parameter combinations are an elaboration-time error:
- NRD < 1
- NWR < 1
- NREGS not a power of two

Optional Feature:
SCR1_MPRF_BYPASS_EN
- Defined: write-to-read forwarding.
  - If any w_req[j] targets rs_addr[i] != 0 in the current cycle, rs_data[i] = w_data of the highest such j.
  - rs_busy[i] reflects the same-cycle clear. It is 0 unless a same-cycle rsv_req targets that address; then it stays at the current pend value, with no reserve forwarding.
  - Flush is not forwarded.
- Undefined: reads return registered state only; one cycle of write-to-read latency.

Test Plan:
1. Reset: assert rst, release, read all addresses on every port -> rs_data = 0, rs_busy = 0, pend_cnt = 0.
2. Write x5 = 0xDEADBEEF on port 0; next cycle read x5 on all NRD ports -> 0xDEADBEEF. Write x0 = 0x1234 -> x0 reads 0.
3. Same-cycle conflict: port 0 writes x7 = 0x11, port 1 writes x7 = 0x22 -> x7 = 0x22.
4. Scoreboard and counter:
   - Reserve x3 and x9 -> next cycle rs_busy = 1 for both, pend_cnt = 2.
   - Write x3 together with a reserve of x3 on the other port -> x3 stays busy, pend_cnt = 2.
   - Write x9 -> pend_cnt = 1.
   - Flush -> pend_cnt = 0.
5. Bypass: write x4 = 0xA5A5A5A5 while reading x4 in the same cycle.
   - With SCR1_MPRF_BYPASS_EN: rs_data = 0xA5A5A5A5 and rs_busy = 0 in that cycle.
   - Without: old value in that cycle, new value the next cycle.
6. Mid-operation reset: assert rst asynchronously while writes and reserves are active -> all registers 0 and pend_cnt = 0 immediately, before the next clk edge.
